// File: rtl/streaming_width_converter_if.sv
// AXI-Stream style beat bundle: data, valid and ready for one direction of a stream.
// The master drives data/valid and the slave drives ready.
interface streaming_width_converter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/streaming_width_converter.sv
// Lossless in-order stream width converter: gathers narrow beats into wide ones,
// splits wide beats into narrow ones, or acts as a register slice at equal width.
module streaming_width_converter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    streaming_width_converter_if.slave  in0_V_V,
    streaming_width_converter_if.master out_V_V
);
    localparam int MAX_W = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int MIN_W = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    localparam int RATIO = MAX_W / MIN_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((MAX_W % MIN_W) != 0) begin : g_bad_ratio
        $fatal(1, "streaming_width_converter: widths %0d/%0d are not integer multiples",
               IN_WIDTH, OUT_WIDTH);
    end

    // Input ready is held low through reset and for the first cycle after it.
    logic rdy_q, rdy_d;

    always_comb begin
        rdy_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, regardless of process ordering.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) rdy_q <= 1'b0;
        else        rdy_q <= rdy_d;
    end

    if (OUT_WIDTH > IN_WIDTH) begin : g_up
        localparam int GW = (RATIO - 1) * IN_WIDTH;

        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic [GW-1:0]        gather_q, gather_d;
        logic [OUT_WIDTH-1:0] data_q, data_d;
        logic                 valid_q, valid_d;
        logic                 last_word, in_ready, in_fire, out_fire;

        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            last_word = (cnt_q == CNT_W'(RATIO - 1));
            in_ready  = rdy_q && !(last_word && valid_q && !out_V_V.tready);
            in_fire   = in0_V_V.tvalid && in_ready;
            out_fire  = valid_q && out_V_V.tready;
            cnt_d     = cnt_q;
            gather_d  = gather_q;
            data_d    = data_q;
            valid_d   = valid_q;
            if (out_fire) valid_d = 1'b0;
            if (in_fire) begin
                if (last_word) begin
                    data_d  = {in0_V_V.tdata, gather_q};
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    gather_d[cnt_q*IN_WIDTH +: IN_WIDTH] = in0_V_V.tdata;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // NOTE: data registers are reset too, because out TDATA must read 0
        // after reset and a partial word must never leak into a later beat.
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                cnt_q    <= '0;
                gather_q <= '0;
                data_q   <= '0;
                valid_q  <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                gather_q <= gather_d;
                data_q   <= data_d;
                valid_q  <= valid_d;
            end
        end

        assign in0_V_V.tready = in_ready;
        assign out_V_V.tdata  = data_q;
        assign out_V_V.tvalid = valid_q;

    end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
        logic [IN_WIDTH-1:0]  hold_q, hold_d;
        logic [CNT_W-1:0]     idx_q, idx_d;
        logic                 valid_q, valid_d;
        logic                 last_slice, in_ready, in_fire, out_fire;
        logic [OUT_WIDTH-1:0] out_data;

        always_comb begin
            last_slice = (idx_q == CNT_W'(RATIO - 1));
            in_ready   = rdy_q && (!valid_q || (last_slice && out_V_V.tready));
            in_fire    = in0_V_V.tvalid && in_ready;
            out_fire   = valid_q && out_V_V.tready;
            out_data   = hold_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
            hold_d     = hold_q;
            idx_d      = idx_q;
            valid_d    = valid_q;
            if (out_fire) begin
                if (last_slice) valid_d = 1'b0;
                else            idx_d   = idx_q + 1'b1;
            end
            // A new wide beat can only be accepted as the last slice leaves.
            if (in_fire) begin
                hold_d  = in0_V_V.tdata;
                idx_d   = '0;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                hold_q  <= '0;
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                hold_q  <= hold_d;
                idx_q   <= idx_d;
                valid_q <= valid_d;
            end
        end

        assign in0_V_V.tready = in_ready;
        assign out_V_V.tdata  = out_data;
        assign out_V_V.tvalid = valid_q;

    end else begin : g_equal
        logic [OUT_WIDTH-1:0] data_q, data_d;
        logic                 valid_q, valid_d;
        logic                 in_ready, in_fire, out_fire;

        always_comb begin
            in_ready = rdy_q && (!valid_q || out_V_V.tready);
            in_fire  = in0_V_V.tvalid && in_ready;
            out_fire = valid_q && out_V_V.tready;
            data_d   = data_q;
            valid_d  = valid_q;
            if (out_fire) valid_d = 1'b0;
            if (in_fire) begin
                data_d  = in0_V_V.tdata;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign in0_V_V.tready = in_ready;
        assign out_V_V.tdata  = data_q;
        assign out_V_V.tvalid = valid_q;
    end
endmodule
